vector_load_unit: RTL
=====================

# vector_load_unit

Sequential vector load engine that fills one vector register from data memory. On `start`, it fetches `VECTOR_SIZE` elements from memory one at a time using a base address and stride. It assembles them into a local buffer and commits the whole vector in a single cycle through the vector register file write port (`we3`/`v3`/`wd3`). It is the producer side of that write port and sits between the decode/issue logic and `register_file_vectorial`.

## Interface
- `WIDTH`, 16, element width in bits
- `VECTOR_SIZE`, 16, elements per vector
- `NUM_VECTORES`, 16, number of vector registers
- `ADDR_WIDTH`, 16, memory address width
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  launch request, sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  address of element 0
- `stride`  in  ADDR_WIDTH  address increment between elements
- `vdst`  in  $clog2(NUM_VECTORES)  destination vector register
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `mem_req`  out  1  read request valid
- `mem_addr`  out  ADDR_WIDTH  read address, stable while `mem_req` is high
- `mem_gnt`  in  1  request accepted this cycle when high together with `mem_req`
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  WIDTH  read data
- `we3`  out  1  register file write enable
- `v3`  out  $clog2(NUM_VECTORES)  register file write index
- `wd3`  out  WIDTH x [VECTOR_SIZE]  register file write data (unpacked array)

## Operation
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE
  - On `start`: latch `base_addr` into the address register, latch `stride` and `vdst`, clear the element index, go to REQ.
- REQ
  - `mem_req`=1, `mem_addr` = address register.
  - On `mem_gnt`: address register += `stride`, wrapping modulo 2^ADDR_WIDTH; go to WAIT.
- WAIT
  - `mem_req`=0.
  - On `mem_rvalid`: `buffer[idx]` <= `mem_rdata`.
  - If `idx` == VECTOR_SIZE-1, go to WB; otherwise `idx`++ and go to REQ.
- WB
  - `v3`=latched `vdst`, `wd3`=buffer.
  - `we3`=1 unless latched `vdst`==0 (register 0 reads as zero, so the write is suppressed).
  - `done`=1; go to IDLE.
- At most one outstanding memory request. Elements are stored strictly in order: element k comes from `base_addr + k*stride`.
- `start` while busy is ignored; no queueing.
- `mem_rvalid` outside WAIT is ignored. `mem_gnt` outside REQ is ignored.
- `stride`=0 is legal: the same address is read VECTOR_SIZE times.
- Reset, asynchronous and possibly mid-operation:
  - FSM returns to IDLE; buffer, index, and latched fields are cleared.
  - All outputs go to 0 immediately: `busy`, `done`, `mem_req`, `mem_addr`, `we3`, `v3`, `wd3`.
  - A `mem_rvalid` arriving after reset release, for a request already in flight, is ignored.

## Timing
- `start` is sampled at edge 0; `busy` and `mem_req` are high from cycle 1.
- With `mem_gnt` held at 1 and `mem_rvalid` one cycle after the grant, each element takes 2 cycles.
  - Final `mem_rvalid` arrives in cycle 2*VECTOR_SIZE (cycle 32 at defaults).
  - `we3` and `done` are high in cycle 2*VECTOR_SIZE+1 (cycle 33); `busy` is low in the following cycle.
- A new `start` is accepted in the first IDLE cycle after `done`; the back-to-back issue gap is 1 cycle.
- Grant and data stalls of any length stretch REQ and WAIT respectively; there is no timeout.
- `wd3` updates only at element capture and holds between loads. `we3` is never high for more than one cycle per load.

## Structure
- Package `vload_pkg`:
  - state enum `vload_state_t` {IDLE, REQ, WAIT, WB};
  - default constants for WIDTH, VECTOR_SIZE, NUM_VECTORES, ADDR_WIDTH.
- One sub-module is natural: `vector_assembly_buffer`, holding VECTOR_SIZE x WIDTH registers.
  - Inputs: `wr_en`, `idx`, `din`, `clr`.
  - Output: the full vector, connected directly to `wd3`.
  - Cleared by `rst_n` and on `start`.
- Top level holds the FSM, index counter, and address accumulator.

## Test plan
- Basic load:
  - Stimulus: memory returns `addr`+0x100; `base`=0x0010, `stride`=1, `vdst`=3, immediate grant.
  - Response: `we3` high for exactly one cycle, in cycle 33; `v3`=3; `wd3[k]`=0x0110+k; `done` coincident with `we3`.
- Strided wrap:
  - Stimulus: `base`=0xFFF0, `stride`=4.
  - Response: request addresses are 0xFFF0, 0xFFF4, 0xFFF8, 0xFFFC, 0x0000, … 0x002C.
- Stalls:
  - Stimulus: `mem_gnt` delayed 3 cycles and `rvalid` delayed 2 cycles on every element.
  - Response: `mem_addr` holds stable while `mem_req` is high; data is still correct; `we3` lands in cycle 1+7*16=113.
- vdst=0:
  - Stimulus: a full load with `vdst`=0.
  - Response: 16 requests are issued, `done` pulses, `we3` stays 0.
- Start while busy plus spurious valid:
  - Stimulus: `start` pulsed mid-load; `mem_rvalid` pulsed while in REQ.
  - Response: both are ignored; only one `done`; buffer contents are unchanged by the spurious valid.
- Reset mid-operation:
  - Stimulus: `rst_n` low asynchronously after element 7 is captured.
  - Response: `busy`, `mem_req`, `we3` drop immediately and `wd3` reads all zeros; a subsequent load with a new `start` completes normally.

Source files
------------

// File: rtl/vector_load_unit_pkg.sv
// rtl/vector_load_unit_pkg.sv - shared types and default sizes for the vector load unit
package vload_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_VECTOR_SIZE  = 16;
    localparam int DEF_NUM_VECTORES = 16;
    localparam int DEF_ADDR_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } vload_state_t;

endpackage

// File: rtl/vector_load_unit_if.sv
// rtl/vector_load_unit_if.sv - single-outstanding memory read port used by the vector load unit
interface vload_mem_if #(
    parameter int WIDTH      = vload_pkg::DEF_WIDTH,
    parameter int ADDR_WIDTH = vload_pkg::DEF_ADDR_WIDTH
);

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [WIDTH-1:0]      mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/vector_assembly_buffer.sv
// rtl/vector_assembly_buffer.sv - element-addressed staging registers for one vector
module vector_assembly_buffer
    import vload_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
    parameter int IDX_WIDTH   = (DEF_VECTOR_SIZE > 1) ? $clog2(DEF_VECTOR_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] idx,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     vec [VECTOR_SIZE]
);

    logic [WIDTH-1:0] r_vec [VECTOR_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VECTOR_SIZE; i++) r_vec[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < VECTOR_SIZE; i++) r_vec[i] <= '0;
        end else if (wr_en) begin
            r_vec[idx] <= din;
        end
    end

    assign vec = r_vec;

endmodule

// File: rtl/vector_load_unit.sv
// rtl/vector_load_unit.sv - strided element-by-element vector load committed in one register-file write
module vector_load_unit
    import vload_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int VECTOR_SIZE  = DEF_VECTOR_SIZE,
    parameter int NUM_VECTORES = DEF_NUM_VECTORES,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [ADDR_WIDTH-1:0]           stride,
    input  logic [$clog2(NUM_VECTORES)-1:0] vdst,
    output logic                            busy,
    output logic                            done,
    vload_mem_if.master                     mem,
    output logic                            we3,
    output logic [$clog2(NUM_VECTORES)-1:0] v3,
    output logic [WIDTH-1:0]                wd3 [VECTOR_SIZE]
);

    localparam int IDX_WIDTH  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int VREG_WIDTH = $clog2(NUM_VECTORES);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VECTOR_SIZE - 1);

    vload_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [VREG_WIDTH-1:0] r_vdst;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_req;
    logic                  r_we3;
    logic                  w_launch;
    logic                  w_capture;

    assign w_launch  = (r_state == IDLE) && start;
    assign w_capture = (r_state == WAIT) && mem.mem_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_stride  <= '0;
            r_vdst    <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mem_req <= 1'b0;
            r_we3     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_we3  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr    <= base_addr;
                        r_stride  <= stride;
                        r_vdst    <= vdst;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_mem_req <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        r_addr    <= r_addr + r_stride;
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_capture) begin
                        if (r_idx == LAST_IDX) begin
                            // Register 0 is hardwired to zero, so its write is dropped.
                            r_we3   <= (r_vdst != '0);
                            r_done  <= 1'b1;
                            r_state <= WB;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_mem_req <= 1'b1;
                            r_state   <= REQ;
                        end
                    end
                end
                WB: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    vector_assembly_buffer #(
        .WIDTH       (WIDTH),
        .VECTOR_SIZE (VECTOR_SIZE),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_launch),
        .wr_en (w_capture),
        .idx   (r_idx),
        .din   (mem.mem_rdata),
        .vec   (wd3)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign we3          = r_we3;
    assign v3           = r_vdst;
    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_addr;

endmodule
